cla_clk: RTL and testbench



---
 rtl/cla_clk.sv | 81 ++++++++
 tb/tb_cla_clk.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/cla_clk.sv
`default_nettype none
// ============================================================================
// Module   : cla_clk
// Purpose  : Two-stage registered 32-bit adder {co_cla, s_cla} = a + b + ci,
//            built from eight 4-bit carry-lookahead groups rippling group carries.
// Revision : 1.0 - initial release
// ============================================================================
module cla_clk (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        ci,
    output logic [31:0] s_cla,
    output logic        co_cla
);

    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        ci_q, ci_d;
    logic [31:0] s_q, s_d;
    logic        co_q, co_d;

    logic [8:0]  w_c;
    logic [31:0] w_sum;

    assign w_c[0] = ci_q;

    // Each group resolves its four internal carries in two levels (AND-OR);
    // only the group carry-out travels to the next group.
    generate
        for (genvar k = 0; k < 8; k++) begin : g_blk
            logic [3:0] w_a, w_b, w_g, w_p, w_cb;

            assign w_a = a_q[4*k +: 4];
            assign w_b = b_q[4*k +: 4];
            assign w_g = w_a & w_b;
            assign w_p = w_a | w_b;

            assign w_cb[0] = w_c[k];
            assign w_cb[1] = w_g[0] | (w_p[0] & w_c[k]);
            assign w_cb[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[k]);
            assign w_cb[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                           | (w_p[2] & w_p[1] & w_p[0] & w_c[k]);
            assign w_c[k+1] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                            | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                            | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[k]);

            assign w_sum[4*k +: 4] = w_a ^ w_b ^ w_cb;
        end
    endgenerate

    always_comb begin
        a_d  = a;
        b_d  = b;
        ci_d = ci;
        s_d  = w_sum;
        co_d = w_c[8];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_q  <= 32'h0;
            b_q  <= 32'h0;
            ci_q <= 1'b0;
            s_q  <= 32'h0;
            co_q <= 1'b0;
        end else begin
            a_q  <= a_d;
            b_q  <= b_d;
            ci_q <= ci_d;
            s_q  <= s_d;
            co_q <= co_d;
        end
    end

    assign s_cla  = s_q;
    assign co_cla = co_q;

endmodule
`default_nettype wire

// File: tb/tb_cla_clk.sv
`default_nettype none
// ============================================================================
// Module   : tb_cla_clk
// Purpose  : Scoreboard bench for cla_clk: expected sums are queued as operands
//            are driven and compared against the registered outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cla_clk;

    logic        clock;
    logic        reset_n;
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic [31:0] s_cla;
    logic        co_cla;

    typedef struct {
        logic [32:0] v;
        string       tag;
    } ent_t;

    ent_t exp_q[$];
    int   total;
    int   bad;

    cla_clk dut (
        .clock  (clock),
        .reset_n(reset_n),
        .a      (a),
        .b      (b),
        .ci     (ci),
        .s_cla  (s_cla),
        .co_cla (co_cla)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [32:0] exp_v);
        total++;
        assert ({co_cla, s_cla} === exp_v) else begin
            bad++;
            $error("FAIL %s: observed co=%0b s=%h, expected co=%0b s=%h",
                   tag, co_cla, s_cla, exp_v[32], exp_v[31:0]);
        end
    endtask

    // One cycle: compare the result now leaving the pipe, then drive new operands.
    task automatic step(input logic [31:0] ta, input logic [31:0] tb_v,
                        input logic tci, input string tag);
        ent_t e;
        @(negedge clock);
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL sb_empty: observed empty queue, expected an entry");
        end else begin
            e = exp_q.pop_front();
            check(e.tag, e.v);
        end
        a  = ta;
        b  = tb_v;
        ci = tci;
        e.v   = {1'b0, ta} + {1'b0, tb_v} + {32'h0, tci};
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    // Release at a falling edge with the held operands; the first edge after
    // release only fills stage 1, so the pipe still shows zero one cycle later.
    task automatic release_reset(input string tag);
        ent_t e;
        @(negedge clock);
        reset_n = 1'b1;
        exp_q.delete();
        e.v   = 33'h0;
        e.tag = {tag, "_first_edge"};
        exp_q.push_back(e);
        e.v   = {1'b0, a} + {1'b0, b} + {32'h0, ci};
        e.tag = {tag, "_first_result"};
        exp_q.push_back(e);
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        reset_n = 1'b0;
        a       = 32'h1234_5678;
        b       = 32'h0000_0001;
        ci      = 1'b1;

        #1;
        check("reset_initial", 33'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("in_reset", 33'h0);
        end

        release_reset("rel1");

        step(32'h0000_0000, 32'h0000_0000, 1'b0, "zero");
        step(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, "full_carry");
        step(32'h0000_FFFF, 32'hFFFF_0000, 1'b0, "halves");
        step(32'h135F_A562, 32'h3561_4642, 1'b0, "mixed");
        step(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "max");
        step(32'h8000_0000, 32'h8000_0000, 1'b0, "msb_carry");
        step(32'h0F0F_0F0F, 32'h00F0_F0F1, 1'b1, "group_mix");
        for (int i = 0; i < 8; i++)
            step($urandom, $urandom, 1'($urandom_range(1, 0)), "rand");
        step(32'hDEAD_BEEF, 32'h2152_4111, 1'b0, "pre_rst_a");
        step(32'hCAFE_F00D, 32'h1234_5678, 1'b1, "pre_rst_b");

        // Drop reset between edges while two results are in flight.
        @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_clear", 33'h0);
        a  = 32'h0000_0005;
        b  = 32'h0000_0006;
        ci = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            check("held_reset", 33'h0);
        end

        release_reset("rel2");
        step(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, "post_rst");
        step(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, "wrap");
        for (int i = 0; i < 3; i++)
            step(32'h0, 32'h0, 1'b0, "drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed sim time limit, expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
